// File: rtl/pce_pkg.sv
// Shared types and width helpers for the product-code encoder.
// PCE_SECDED_EN widens every Hamming codeword by one overall-parity bit.
package pce_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, ENCODE, OUT} state_t;

  // Smallest p with 2^p >= k + p + 1.
  function automatic int parity_count(input int k);
    int p;
    p = 1;
    while ((1 << p) < k + p + 1) p++;
    return p;
  endfunction

  function automatic int enc_width(input int k);
`ifdef PCE_SECDED_EN
    return k + parity_count(k) + 1;
`else
    return k + parity_count(k);
`endif
  endfunction

  function automatic int diag_width(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  function automatic int cw_width(input int rows, input int cols);
    return rows * cols + enc_width(rows) + enc_width(cols)
           + enc_width(diag_width(rows, cols));
  endfunction

endpackage

// File: rtl/hamming_sec_enc.sv
// Combinational Hamming single-error-correcting encoder for a K-bit vector.
// With PCE_SECDED_EN an overall even-parity bit is prepended as the new MSB.
module hamming_sec_enc
  import pce_pkg::*;
#(
  parameter int K = 8,
  localparam int P = parity_count(K),
  localparam int N = K + P,
  localparam int W = enc_width(K)
) (
  input  logic [K-1:0] data,
  output logic [W-1:0] code
);

  logic [N-1:0] sec;

  always_comb begin
    sec = '0;
    // Position q (1-based) holds data bit q-1-clog2(q+1) unless q is a power of two.
    for (int q = 1; q <= N; q++) begin
      if ((q & (q - 1)) != 0) sec[q-1] = data[q - 1 - $clog2(q + 1)];
    end
    for (int j = 0; j < P; j++) begin
      for (int q = 1; q <= N; q++) begin
        if ((((q >> j) & 1) == 1) && ((q & (q - 1)) != 0))
          sec[(1 << j) - 1] = sec[(1 << j) - 1] ^ sec[q-1];
      end
    end
  end

`ifdef PCE_SECDED_EN
  assign code = {^sec, sec};
`else
  assign code = sec;
`endif

endmodule

// File: rtl/product_code_encoder.sv
// Streaming ROWSxCOLS product-code encoder: row/column/anti-diagonal parity, each Hamming-encoded.
// Define PCE_SECDED_EN to extend each parity codeword with an overall parity bit (SECDED).
module product_code_encoder
  import pce_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int ND   = diag_width(ROWS, COLS),
  localparam int NH   = enc_width(ROWS),
  localparam int NV   = enc_width(COLS),
  localparam int NDE  = enc_width(ND),
  localparam int CW_W = cw_width(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [COLS-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW_W-1:0] out_code,
  output logic            busy
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  state_t               state;
  logic [RW-1:0]        row_cnt;
  logic [ROWS*COLS-1:0] data_reg;
  logic [ROWS-1:0]      h_reg;
  logic [COLS-1:0]      v_reg;
  logic [ND-1:0]        d_reg;
  logic [RW-1:0]        cur_row;
  logic [ND-1:0]        d_base;
  logic [ND-1:0]        d_row;
  logic [NH-1:0]        h_enc;
  logic [NV-1:0]        v_enc;
  logic [NDE-1:0]       d_enc;
  logic                 accept;

  assign accept  = in_valid && in_ready;
  assign cur_row = (state == COLLECT) ? row_cnt : '0;
  assign busy    = (state != IDLE);

  // Row 0 column c lands on diagonal ND-1-c; each later row shifts one step toward D[0].
  always_comb begin
    d_base = '0;
    for (int c = 0; c < COLS; c++) d_base[ND-1-c] = in_data[c];
  end
  assign d_row = d_base >> cur_row;

  hamming_sec_enc #(.K(ROWS)) u_h_enc (.data(h_reg), .code(h_enc));
  hamming_sec_enc #(.K(COLS)) u_v_enc (.data(v_reg), .code(v_enc));
  hamming_sec_enc #(.K(ND))   u_d_enc (.data(d_reg), .code(d_enc));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row_cnt   <= '0;
      data_reg  <= '0;
      h_reg     <= '0;
      v_reg     <= '0;
      d_reg     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_code  <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            // First row restarts the running V/D accumulators.
            data_reg[COLS-1:0] <= in_data;
            h_reg[0]           <= ^in_data;
            v_reg              <= in_data;
            d_reg              <= d_row;
            if (ROWS == 1) begin
              in_ready <= 1'b0;
              state    <= ENCODE;
            end else begin
              row_cnt <= RW'(1);
              state   <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            data_reg[int'(row_cnt)*COLS +: COLS] <= in_data;
            h_reg[row_cnt]                       <= ^in_data;
            v_reg                                <= v_reg ^ in_data;
            d_reg                                <= d_reg ^ d_row;
            if (row_cnt == LAST_ROW) begin
              row_cnt  <= '0;
              in_ready <= 1'b0;
              state    <= ENCODE;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end
        ENCODE: begin
          out_code  <= {data_reg, h_enc, v_enc, d_enc};
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_product_code_encoder.sv
// Scoreboard testbench for the 8x8 product-code encoder.
// Honours PCE_SECDED_EN for field widths and golden codewords.
module tb_product_code_encoder;

`ifdef PCE_SECDED_EN
  localparam int XB = 1;
  localparam logic [12:0] EXP_H1 = 13'h1007;
  localparam logic [12:0] EXP_V1 = 13'h1007;
  localparam logic [20:0] EXP_D1 = 21'h188008;
`else
  localparam int XB = 0;
  localparam logic [11:0] EXP_H1 = 12'h007;
  localparam logic [11:0] EXP_V1 = 12'h007;
  localparam logic [19:0] EXP_D1 = 20'h88008;
`endif
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int NH   = 12 + XB;
  localparam int NV   = 12 + XB;
  localparam int NDE  = 20 + XB;
  localparam int CW   = ROWS * COLS + NH + NV + NDE;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [COLS-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   out_code;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle_cnt = 0;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] pattern_code;

  product_code_encoder #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference Hamming encoder: walks positions with an explicit data counter.
  function automatic logic [31:0] ham(input logic [31:0] d, input int k);
    int p, n, di;
    logic [31:0] c;
    logic par;
    p = 0;
    while ((1 << p) < k + p + 1) p++;
    n = k + p;
    c = '0;
    di = 0;
    for (int q = 1; q <= n; q++) begin
      if ((q & (q - 1)) != 0) begin
        c[q-1] = d[di];
        di++;
      end
    end
    for (int j = 0; j < p; j++) begin
      par = 1'b0;
      for (int q = 1; q <= n; q++) if (((q >> j) & 1) == 1) par ^= c[q-1];
      c[(1 << j) - 1] = par;
    end
    if (XB == 1) c[n] = ^c;
    return c;
  endfunction

  function automatic logic [CW-1:0] golden(input logic [63:0] blk);
    logic [31:0] h, v, d, he, ve, de;
    logic b;
    h = '0; v = '0; d = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        b = blk[r*COLS + c];
        h[r] ^= b;
        v[c] ^= b;
        d[ROWS + COLS - 2 - r - c] ^= b;
      end
    end
    he = ham(h, ROWS);
    ve = ham(v, COLS);
    de = ham(d, ROWS + COLS - 1);
    return {blk, he[NH-1:0], ve[NV-1:0], de[NDE-1:0]};
  endfunction

  function automatic int syndrome(input logic [31:0] f, input int n);
    int s;
    s = 0;
    for (int q = 1; q <= n; q++) if (f[q-1]) s ^= q;
    return s;
  endfunction

  task automatic send_row(input logic [COLS-1:0] row);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = row;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL row_accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] blk, input int stall);
    exp_q.push_back(golden(blk));
    for (int r = 0; r < ROWS; r++) begin
      send_row(blk[r*COLS +: COLS]);
      if (r == 3) repeat (stall) @(negedge clk);
    end
  endtask

  task automatic collect(input int budget, output logic got, output logic [CW-1:0] code);
    int w;
    w = 0;
    while (out_valid !== 1'b1 && w < budget) begin
      @(negedge clk);
      w++;
    end
    got  = (out_valid === 1'b1);
    code = out_code;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b required 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
    n_checks++; if (out_code !== '0) begin n_fail++; $display("[TB] FAIL reset_out_code: got %h required 0", out_code); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_in_ready: got %b required 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_zero_block();
    logic got;
    logic [CW-1:0] code, exp;
    int t0;
    out_ready = 1'b1;
    t0 = cycle_cnt;
    send_block(64'h0, 0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_encode_cycle: out_valid=%b required 0", out_valid); end
    collect(40, got, code);
    exp = exp_q.pop_front();
    n_checks++; if (!got || code !== exp) begin n_fail++; $display("[TB] FAIL zero_code: got %h required %h (valid=%b)", code, exp, got); end
    n_checks++; if (code !== '0) begin n_fail++; $display("[TB] FAIL zero_const: got %h required 0", code); end
    n_checks++; if (cycle_cnt - t0 != ROWS + 1) begin n_fail++; $display("[TB] FAIL zero_latency: got %0d required %0d", cycle_cnt - t0, ROWS + 1); end
    @(negedge clk);
  endtask

  task automatic test_single_bit();
    logic got;
    logic [CW-1:0] code, exp;
    out_ready = 1'b1;
    send_block(64'h1, 0);
    collect(40, got, code);
    exp = exp_q.pop_front();
    n_checks++; if (!got || code !== exp) begin n_fail++; $display("[TB] FAIL single_code: got %h required %h (valid=%b)", code, exp, got); end
    n_checks++; if (code[NDE+NV +: NH] !== EXP_H1) begin n_fail++; $display("[TB] FAIL single_h_enc: got %h required %h", code[NDE+NV +: NH], EXP_H1); end
    n_checks++; if (code[NDE +: NV] !== EXP_V1) begin n_fail++; $display("[TB] FAIL single_v_enc: got %h required %h", code[NDE +: NV], EXP_V1); end
    n_checks++; if (code[NDE-1:0] !== EXP_D1) begin n_fail++; $display("[TB] FAIL single_d_enc: got %h required %h", code[NDE-1:0], EXP_D1); end
    @(negedge clk);
  endtask

  task automatic test_pattern();
    logic got;
    logic [CW-1:0] code, exp;
    logic [31:0] f;
    out_ready = 1'b1;
    send_block(64'h5965_3CAA_CF0F_3333, 0);
    collect(40, got, code);
    exp = exp_q.pop_front();
    pattern_code = code;
    n_checks++; if (!got || code !== exp) begin n_fail++; $display("[TB] FAIL pattern_code: got %h required %h (valid=%b)", code, exp, got); end
    f = 32'(code[NDE+NV +: NH]);
    n_checks++; if (syndrome(f, NH - XB) != 0) begin n_fail++; $display("[TB] FAIL pattern_h_syndrome: got %0d required 0", syndrome(f, NH - XB)); end
    f = 32'(code[NDE +: NV]);
    n_checks++; if (syndrome(f, NV - XB) != 0) begin n_fail++; $display("[TB] FAIL pattern_v_syndrome: got %0d required 0", syndrome(f, NV - XB)); end
    f = 32'(code[NDE-1:0]);
    n_checks++; if (syndrome(f, NDE - XB) != 0) begin n_fail++; $display("[TB] FAIL pattern_d_syndrome: got %0d required 0", syndrome(f, NDE - XB)); end
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic got;
    logic [CW-1:0] code, exp;
    int t0;
    out_ready = 1'b1;
    t0 = cycle_cnt;
    send_block(64'h5965_3CAA_CF0F_3333, 3);
    collect(40, got, code);
    exp = exp_q.pop_front();
    n_checks++; if (!got || code !== exp) begin n_fail++; $display("[TB] FAIL stall_code: got %h required %h (valid=%b)", code, exp, got); end
    n_checks++; if (code !== pattern_code) begin n_fail++; $display("[TB] FAIL stall_vs_unstalled: got %h required %h", code, pattern_code); end
    n_checks++; if (cycle_cnt - t0 != ROWS + 4) begin n_fail++; $display("[TB] FAIL stall_latency: got %0d required %0d", cycle_cnt - t0, ROWS + 4); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic got;
    logic [CW-1:0] code, exp;
    out_ready = 1'b0;
    send_block(64'hDEAD_BEEF_0123_4567, 0);
    collect(40, got, code);
    exp = exp_q.pop_front();
    n_checks++; if (!got || code !== exp) begin n_fail++; $display("[TB] FAIL bp_code: got %h required %h (valid=%b)", code, exp, got); end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 8'hA5;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready[%0d]: got %b required 0", i, in_ready); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_out_valid[%0d]: got %b required 1", i, out_valid); end
      n_checks++; if (out_code !== code) begin n_fail++; $display("[TB] FAIL bp_stable[%0d]: got %h required %h", i, out_code, code); end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_handshake_in_ready: got %b required 0", in_ready); end
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_after_in_ready: got %b required 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_after_out_valid: got %b required 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_after_busy: got %b required 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic got;
    logic [CW-1:0] code, exp;
    logic [63:0] blk;
    int t0, t1;
    out_ready = 1'b1;
    t0 = cycle_cnt;
    blk = {$urandom, $urandom};
    send_block(blk, 0);
    collect(40, got, code);
    exp = exp_q.pop_front();
    n_checks++; if (!got || code !== exp) begin n_fail++; $display("[TB] FAIL b2b_code_a: got %h required %h (valid=%b)", code, exp, got); end
    @(negedge clk);
    t1 = cycle_cnt;
    n_checks++; if (t1 - t0 != ROWS + 2) begin n_fail++; $display("[TB] FAIL b2b_period: got %0d required %0d", t1 - t0, ROWS + 2); end
    blk = {$urandom, $urandom};
    send_block(blk, 0);
    collect(40, got, code);
    exp = exp_q.pop_front();
    n_checks++; if (!got || code !== exp) begin n_fail++; $display("[TB] FAIL b2b_code_b: got %h required %h (valid=%b)", code, exp, got); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_block();
    logic got;
    logic [CW-1:0] code, exp;
    out_ready = 1'b1;
    for (int r = 0; r < 6; r++) send_row(8'hFF - 8'(r));
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_in_ready: got %b required 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_out_valid: got %b required 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_busy: got %b required 0", busy); end
    n_checks++; if (out_code !== '0) begin n_fail++; $display("[TB] FAIL mid_rst_out_code: got %h required 0", out_code); end
    rst = 1'b0;
    @(negedge clk);
    send_block(64'h0F1E_2D3C_4B5A_6978, 0);
    collect(40, got, code);
    exp = exp_q.pop_front();
    n_checks++; if (!got || code !== exp) begin n_fail++; $display("[TB] FAIL mid_rst_fresh_code: got %h required %h (valid=%b)", code, exp, got); end
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    pattern_code = '0;
    @(negedge clk);
    test_reset();
    test_zero_block();
    test_single_bit();
    test_pattern();
    test_stall();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_block();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/product_code_encoder.md
# product_code_encoder

Streaming product-code parity encoder: accepts a ROWS×COLS data block one row per cycle and computes row (H), column (V) and anti-diagonal (D) parity vectors. Each parity vector is protected by its own single-error-correcting Hamming code. The block then presents the full codeword (data plus three encoded parity vectors) on a valid/ready output. It is the parametrised, clocked successor of the fixed 8×8 combinational encoder and feeds the storage/link framing stage.

## Interface
- ROWS, 8, rows per block (≥2)
- COLS, 8, bits per row (≥2)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  row data valid
- in_ready  out  1  block can accept a row
- in_data  in  COLS  one row; bit c = column c
- out_valid  out  1  codeword valid
- out_ready  in  1  downstream accepts codeword
- out_code  out  CW_W  codeword (widths in Operation)
- busy  out  1  high whenever not in IDLE

## Operation
- Block layout: row r occupies bits [r*COLS +: COLS] of the data field; row 0 arrives first.
- Parity definitions:
  - H[r] = XOR of row r (ROWS bits).
  - V[c] = XOR of column c over all rows (COLS bits).
  - D[k] = XOR of all bits with r+c = ROWS+COLS−2−k (ND = ROWS+COLS−1 bits; D[0] = bit (ROWS−1, COLS−1)).
- H is captured at row acceptance; V and D are running XORs cleared at block start.
- Hamming encode of a k-bit vector:
  - Parity count p is the smallest value with 2^p ≥ k+p+1; codeword length n = k+p.
  - Position q (1-based) maps to codeword bit q−1.
  - Parity bits sit at positions 2^j; data bits fill the remaining positions in ascending order, data bit 0 at position 3.
  - Parity 2^j = XOR of all other positions with bit j set.
  - 8×8 case: H 8→12, V 8→12, D 15→20.
- out_code = {data, H_enc, V_enc, D_enc}, MSB first. CW_W = ROWS*COLS + nH + nV + nD (108 for 8×8).
- FSM:
  - IDLE: in_ready=1. An accepted row clears V/D, stores row 0, and moves to COLLECT (or to ENCODE if ROWS accepted).
  - COLLECT: in_ready=1. Each accepted row increments row_cnt. Acceptance of row ROWS−1 moves to ENCODE.
  - ENCODE: in_ready=0. Registers all three Hamming encodings plus data into out_code. Next state is OUT.
  - OUT: out_valid=1 and out_code stable until out_valid&out_ready, then IDLE.
- in_valid while in_ready=0 is ignored; no data loss is the upstream's responsibility.
- A stall of in_valid mid-block holds all state; there is no timeout.

## Timing
- Reset values: in_ready=0 in the reset cycle, then 1 (IDLE); out_valid=0, out_code=0, busy=0, row_cnt=0, accumulators=0.
- Latency: out_valid rises 2 cycles after the cycle in which the last row is accepted (ENCODE cycle, then OUT registered).
- Minimum block period: ROWS + 2 cycles with out_ready held high. The handshake in OUT returns to IDLE, so in_ready reasserts in the cycle after out_valid&out_ready.
- in_ready is low in the cycle where the handshake completes, so no overlap of blocks occurs.
- rst asserted at any point, including mid-COLLECT or during OUT with out_ready low, returns to reset values on the next edge. A partial block is discarded and the partially presented codeword is dropped.
- row_cnt width is clog2(ROWS); it wraps to 0 on leaving COLLECT.

## Configuration
- PCE_SECDED_EN defined: each Hamming codeword gains an overall even-parity bit as its new MSB, covering all n bits. nH, nV and nD each grow by 1 (CW_W=111 for 8×8).
- PCE_SECDED_EN undefined: plain SEC codewords as specified above.

## Structure
- Shared package pce_pkg:
  - Function for the parity-count computation.
  - Functions for derived widths (nH/nV/nD/CW_W).
  - FSM state enum {IDLE, COLLECT, ENCODE, OUT}.
- One sub-module hamming_sec_enc, parametrised by K (data width), purely combinational and instanced three times. It includes the SECDED bit under the macro.

## Test plan
- 8×8, all-zero block, out_ready=1: codeword = 108'h0; out_valid 2 cycles after row 7 is accepted.
- 8×8, only data bit (r0,c0)=1: H=0x01→H_enc=12'h007, V_enc=12'h007, D=1<<14→D_enc=20'h88008.
- 8×8, 64'h5965_3CAA_CF0F_3333 rows LSB-row first: H/V/D match the golden model, and each Hamming field decodes with zero syndrome.
- in_valid deasserted for 3 cycles between rows 3 and 4: result is identical to the unstalled run; latency is extended by 3.
- out_ready low for 5 cycles in OUT: out_code stable, in_ready=0 throughout, and in_valid pulses are ignored. Then accept; in_ready=1 on the next cycle.
- rst pulsed after row 5: all outputs are at reset values on the next edge. A fresh 8-row block then produces the correct codeword with no residue of the old V/D.
